// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver.
// Contents: default data-path width, the machine-external-interrupt mask
// (MEIP, bit 11), the default receive FIFO depth and the receive FSM state enum.
package uart_rx_pkg;

    localparam int unsigned RX_WIDTH      = 32;
    localparam logic [31:0] MEIP_MASK     = 32'h0000_0800;
    localparam int unsigned RX_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO for the UART receiver.
// Ports: clk/reset (async active-low); push + push_data write one byte
// (ignored when full unless popped in the same cycle); pop removes the head
// (ignored when empty); full/empty flags; head is the oldest byte, 0 when empty.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == {CNT_W{1'b0}});
    assign head  = empty ? 8'h00 : mem_q[rd_ptr_q];

    // Qualify requests and compute next pointers/occupancy.
    // At full, a push is accepted only when a pop frees the head slot in the same cycle.
    always_comb begin
        pop_ok_s  = pop & ~empty;
        push_ok_s = push & (~full | pop_ok_s);
        wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d  = pop_ok_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer, occupancy and storage registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, idle-high line.
// Ports: clk, reset (async active-low); clk_rate = clock cycles per bit;
// uart_in serial line; rd_en pops the FIFO head; err_clr clears sticky flags.
// Outputs: rx_data (FIFO head, 0 when empty), rx_empty, frame_err, overrun,
// rx_irq (MEIP mask while the FIFO holds data).
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned WIDTH      = RX_WIDTH,
    parameter int unsigned FIFO_DEPTH = RX_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] clk_rate,
    input  logic             uart_in,
    input  logic             rd_en,
    input  logic             err_clr,
    output logic [7:0]       rx_data,
    output logic             rx_empty,
    output logic             frame_err,
    output logic             overrun,
    output logic [WIDTH-1:0] rx_irq
);

    rx_state_e        state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       sync_q, sync_d;
    logic             rx_prev_q, rx_prev_d;
    logic             push_q, push_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             rx_s;
    logic             fall_s;
    logic             ferr_set_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;

    assign rx_s   = sync_q[1];
    assign fall_s = rx_prev_q & ~rx_s;

    // Synchronizer and frame decoder; below 4 cycles/bit the decoder is parked in IDLE.
    always_comb begin
        sync_d     = {sync_q[0], uart_in};
        rx_prev_d  = rx_s;
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        push_d     = 1'b0;
        ferr_set_s = 1'b0;
        if (clk_rate < WIDTH'(4)) begin
            state_d   = ST_IDLE;
            cnt_d     = {WIDTH{1'b0}};
            bit_idx_d = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fall_s) begin
                        state_d = ST_START;
                        cnt_d   = {WIDTH{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    // Mid start bit: a line that has gone high again was a glitch.
                    if (cnt_q == (clk_rate >> 1)) begin
                        cnt_d     = {WIDTH{1'b0}};
                        bit_idx_d = 3'd0;
                        state_d   = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == (clk_rate - WIDTH'(1))) begin
                        shift_d = {rx_s, shift_q[7:1]};
                        cnt_d   = {WIDTH{1'b0}};
                        if (bit_idx_q == 3'd7) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_q == (clk_rate - WIDTH'(1))) begin
                        push_d     = rx_s;
                        ferr_set_s = ~rx_s;
                        cnt_d      = {WIDTH{1'b0}};
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = {WIDTH{1'b0}};
                end
            endcase
        end
    end

    // Sticky error flags; a clear in the same cycle as a set wins.
    always_comb begin
        if (err_clr) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            frame_err_d = frame_err_q | ferr_set_s;
            overrun_d   = overrun_q | (push_q & fifo_full_s & ~rd_en);
        end
    end

    // Decoder state, synchronizer and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {WIDTH{1'b0}};
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            sync_q      <= 2'b11;
            rx_prev_q   <= 1'b1;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            sync_q      <= sync_d;
            rx_prev_q   <= rx_prev_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data (shift_q),
        .pop       (rd_en),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (rx_data)
    );

    assign rx_empty  = fifo_empty_s;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rx_irq    = fifo_empty_s ? {WIDTH{1'b0}} : WIDTH'(MEIP_MASK);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven single frames, hand-written
// corner sequences (glitch, overrun, push/pop collision, clear priority,
// reset mid-frame, slow-rate hold) and a randomized run against a queue model.
module tb_uart_rx;

    localparam int W = 32;
    localparam logic [31:0] IRQ_ON = 32'h0000_0800;

    logic         clk;
    logic         reset;
    logic [W-1:0] clk_rate;
    logic         uart_in;
    logic         rd_en;
    logic         err_clr;
    logic [7:0]   rx_data;
    logic         rx_empty;
    logic         frame_err;
    logic         overrun;
    logic [W-1:0] rx_irq;

    int total;
    int bad;

    uart_rx #(.WIDTH(W), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_rate  (clk_rate),
        .uart_in   (uart_in),
        .rd_en     (rd_en),
        .err_clr   (err_clr),
        .rx_data   (rx_data),
        .rx_empty  (rx_empty),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_irq    (rx_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         rate;
        logic [7:0] exp_data;
        logic       exp_empty;
        logic       exp_ferr;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] model_q [$];
    logic       m_ferr;
    logic       m_ovr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_state(input string nm, input logic [7:0] d, input logic emp,
                               input logic fe, input logic ov);
        chk({nm, ".data"},  {24'h0, rx_data},   {24'h0, d});
        chk({nm, ".empty"}, {31'h0, rx_empty},  {31'h0, emp});
        chk({nm, ".irq"},   rx_irq,             emp ? 32'h0 : IRQ_ON);
        chk({nm, ".ferr"},  {31'h0, frame_err}, {31'h0, fe});
        chk({nm, ".ovr"},   {31'h0, overrun},   {31'h0, ov});
    endtask

    // One 8N1 frame of 10*rate cycles. Window e is the cycle after edge e
    // (edge 0 = start bit begins). pop_e/clr_e raise rd_en/err_clr in that
    // window; abort_e pulls reset for 3 cycles and idles the line. -1 = unused.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int rate,
                              input int pop_e, input int clr_e, input int abort_e);
        int idx;
        @(posedge clk);
        #1;
        for (int e = 0; e < 10 * rate; e++) begin
            idx = e / rate;
            if (idx == 0)      uart_in = 1'b0;
            else if (idx == 9) uart_in = stop_bit;
            else               uart_in = d[idx-1];
            rd_en   = (e == pop_e);
            err_clr = (e == clr_e);
            if (abort_e >= 0 && e >= abort_e) uart_in = 1'b1;
            if (e == abort_e) reset = 1'b0;
            if (abort_e >= 0 && e == abort_e + 3) reset = 1'b1;
            @(posedge clk);
            #1;
        end
        uart_in = 1'b1;
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic pulse_pop();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic       stp;
        int         r;
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        uart_in  = 1'b1;
        rd_en    = 1'b0;
        err_clr  = 1'b0;
        clk_rate = 32'd10;

        vecs[0] = '{8'hA5, 1'b1, 10, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 10, 8'h00, 1'b1, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 16, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 16, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'h55, 1'b1, 16, 8'h55, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 13, 8'h80, 1'b0, 1'b0};
        vecs[6] = '{8'h01, 1'b0, 12, 8'h00, 1'b1, 1'b1};

        tick(3);
        check_state("reset", 8'h00, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick(3);

        // Table: one frame each, then drain and clear back to idle state.
        for (int i = 0; i < 7; i++) begin
            clk_rate = vecs[i].rate;
            tick(2);
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].rate, -1, -1, -1);
            tick(4);
            check_state($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_empty,
                        vecs[i].exp_ferr, 1'b0);
            if (!vecs[i].exp_empty) pulse_pop();
            pulse_clr();
            tick(1);
            check_state($sformatf("vec%0d_clean", i), 8'h00, 1'b1, 1'b0, 1'b0);
        end

        // Pop while empty is ignored.
        clk_rate = 32'd10;
        pulse_pop();
        tick(1);
        check_state("pop_empty", 8'h00, 1'b1, 1'b0, 1'b0);

        // Short low glitch is rejected, and a real frame still decodes after it.
        uart_in = 1'b0;
        tick(3);
        uart_in = 1'b1;
        tick(20);
        check_state("glitch", 8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b1, 10, -1, -1, -1);
        tick(4);
        check_state("post_glitch", 8'hC3, 1'b0, 1'b0, 1'b0);
        pulse_pop();

        // Overrun: fifth byte with no reads is dropped.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 10, -1, -1, -1);
        tick(4);
        check_state("ovr", 8'h01, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovr_pop%0d", i), {24'h0, rx_data}, i);
            pulse_pop();
        end
        check_state("ovr_drained", 8'h00, 1'b1, 1'b0, 1'b1);
        pulse_clr();
        check_state("ovr_clr", 8'h00, 1'b1, 1'b0, 1'b0);

        // Pop coincides with the fifth push (push edge is 5+h+9r = 100): no overrun.
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 10, -1, -1, -1);
        send_frame(8'h05, 1'b1, 10, 99, -1, -1);
        tick(4);
        check_state("pushpop", 8'h02, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("pushpop_pop%0d", i), {24'h0, rx_data}, i);
            pulse_pop();
        end
        check_state("pushpop_drained", 8'h00, 1'b1, 1'b0, 1'b0);

        // err_clr in the very cycle frame_err would set (stop decision edge 99).
        send_frame(8'h3C, 1'b0, 10, -1, 98, -1);
        tick(4);
        check_state("clr_prio", 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset during data bit 2 of 0x77, then a clean 0x12.
        send_frame(8'h77, 1'b1, 10, -1, -1, 32);
        tick(10);
        check_state("rst_mid", 8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'h12, 1'b1, 10, -1, -1, -1);
        tick(4);
        check_state("rst_after", 8'h12, 1'b0, 1'b0, 1'b0);
        pulse_pop();
        check_state("rst_drained", 8'h00, 1'b1, 1'b0, 1'b0);

        // clk_rate below 4 keeps the receiver idle.
        clk_rate = 32'd3;
        tick(2);
        send_frame(8'h00, 1'b0, 3, -1, -1, -1);
        tick(4);
        check_state("slow_rate", 8'h00, 1'b1, 1'b0, 1'b0);

        // Randomized frames against a queue model of the FIFO and flags.
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        for (int n = 0; n < 25; n++) begin
            r        = int'($urandom_range(8, 20));
            clk_rate = r;
            tick(2);
            if ($urandom_range(0, 2) == 0) begin
                pulse_pop();
                if (model_q.size() > 0) void'(model_q.pop_front());
            end
            if ($urandom_range(0, 7) == 0) begin
                pulse_clr();
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
            end
            d   = 8'($urandom);
            stp = ($urandom_range(0, 4) != 0);
            send_frame(d, stp, r, -1, -1, -1);
            if (!stp)                   m_ferr = 1'b1;
            else if (model_q.size() < 4) model_q.push_back(d);
            else                        m_ovr = 1'b1;
            tick(4);
            check_state($sformatf("rnd%0d", n),
                        (model_q.size() > 0) ? model_q[0] : 8'h00,
                        model_q.size() == 0, m_ferr, m_ovr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: WIDTH, 32, data-path and interrupt-vector width; matches core `width`.
REQ-002 Parameter: FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16.
REQ-003 Port: clk  in  1  single clock for all state.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: clk_rate  in  WIDTH  clock cycles per bit; same encoding as the transmitter's baud input.
REQ-006 Port: uart_in  in  1  serial line; idle high; 8N1 framing, LSB first.
REQ-007 Port: rd_en  in  1  pop request from the core; a pop when empty is ignored.
REQ-008 Port: err_clr  in  1  clears frame_err and overrun.
REQ-009 Port: rx_data  out  8  FIFO head byte; 0 when empty.
REQ-010 Port: rx_empty  out  1  FIFO empty flag.
REQ-011 Port: frame_err  out  1  sticky; set when a stop bit samples low.
REQ-012 Port: overrun  out  1  sticky; set when a byte arrives with the FIFO full.
REQ-013 Port: rx_irq  out  WIDTH  32'h0000_0800 (MEIP, bit 11) while FIFO non-empty, else 0; ORed with the timer source at top level.

Function
REQ-014 uart_in SHALL pass a 2-flop synchronizer (reset value 1); all decoding SHALL use the synchronized value.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP; the bit counter SHALL be WIDTH bits and the bit index 3 bits.
REQ-016 IDLE: a synchronized 1->0 edge SHALL move to START with counter = 0.
REQ-017 START: at counter == clk_rate>>1, line low -> DATA, counter = 0; line high -> IDLE (glitch rejected, nothing stored).
REQ-018 DATA: at counter == clk_rate-1, shift the sampled bit in at MSB (LSB-first), counter = 0; after the 8th bit -> STOP.
REQ-019 STOP: at counter == clk_rate-1, line high -> push byte; line low -> set frame_err, drop byte; both cases -> IDLE.
REQ-020 A push SHALL occur on the cycle after the stop-bit sample; rx_empty SHALL fall and rx_irq SHALL assert in that same cycle.
REQ-021 Push and pop in the same cycle SHALL both take effect; occupancy is unchanged, and at full this SHALL NOT count as overrun.
REQ-022 A push while full without a pop SHALL drop the new byte and set overrun; stored bytes are unchanged.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-024 rx_data SHALL be combinational from the head entry; a pop advances it on the next clock.
REQ-025 err_clr SHALL take priority over a same-cycle set of frame_err/overrun (clear wins).
REQ-026 clk_rate < 4 SHALL hold the FSM in IDLE; a clk_rate change mid-frame affects only subsequent comparisons.

Reset
REQ-027 On reset low: FSM = IDLE; counters and shift register = 0; synchronizer = 1; FIFO empty; rx_data = 0; rx_empty = 1; frame_err = overrun = 0; rx_irq = 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial byte; after release the block SHALL wait for a fresh falling edge.

Structure
REQ-029 WIDTH, the MEIP mask 32'h0000_0800 and the FSM state enum SHALL live in the shared package included by the core (sc.svh).
REQ-030 The FIFO SHALL be one sub-module, uart_rx_fifo (push, pop, full, empty, head); the FSM stays in uart_rx.

Verification
REQ-031 clk_rate=10, send 0xA5 -> one entry, rx_data=8'hA5, rx_irq=32'h0000_0800; then rd_en for 1 cycle -> rx_empty=1, rx_irq=0.
REQ-032 clk_rate=10, 3-cycle low glitch -> FSM returns to IDLE, rx_empty stays 1, no error flags set.
REQ-033 Send 0x3C with stop bit low -> frame_err=1, FIFO empty; err_clr pulse -> frame_err=0.
REQ-034 Send 5 bytes 0x01..0x05 with no reads -> FIFO holds 0x01..0x04, overrun=1; pop in the same cycle as the 5th push -> 0x02..0x05 held, overrun=0.
REQ-035 Assert reset mid-DATA of byte 0x77, release, send 0x12 -> only 0x12 is received, no error flags.
REQ-036 Loopback with the core transmitter at clk_rate=16, bytes 0x00, 0xFF, 0x55 -> received in order, no error flags.
